// File: rtl/ps2_kbd_sequencer.sv
// ps2_kbd_sequencer: shares the PS2Controller register port between the CPU
// and an autonomous keyboard command sequencer (reset handshake, LED update).
module ps2_kbd_sequencer #(
   parameter int unsigned ack_timeout = 2500000,
   parameter int unsigned bat_timeout = 50000000,
   parameter int unsigned max_retries = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cs,
   input  logic        data_m_access,
   input  logic        data_m_wr_en,
   input  logic [15:0] data_m_data_in,
   input  logic [1:0]  data_m_bytesel,
   output logic        data_m_ack,
   output logic [15:0] data_m_data_out,
   output logic        intr,
   output logic        ps2_cs,
   output logic        ps2_access,
   output logic        ps2_wr_en,
   output logic [1:0]  ps2_bytesel,
   output logic [15:0] ps2_wdata,
   input  logic [15:0] ps2_rdata,
   input  logic        ps2_ack,
   input  logic        ps2_intr,
   input  logic        kbd_reset_req,
   input  logic        led_req,
   input  logic [2:0]  led_mask,
   output logic        seq_busy,
   output logic        seq_done,
   output logic [1:0]  seq_err
);

   localparam int unsigned TW = $clog2(bat_timeout + 1);
   localparam int unsigned RW = (max_retries < 1) ? 1 : $clog2(max_retries + 1);
   localparam logic [TW-1:0] ACK_LIM = TW'(ack_timeout);
   localparam logic [TW-1:0] BAT_LIM = TW'(bat_timeout);
   localparam logic [1:0] BSEL_STAT = 2'b10;
   localparam logic [1:0] BSEL_DATA = 2'b01;
   localparam logic [7:0] KBD_ACK    = 8'hFA;
   localparam logic [7:0] KBD_RESEND = 8'hFE;
   localparam logic [7:0] KBD_BAT_OK = 8'hAA;
   localparam logic [7:0] KBD_BAT_NG = 8'hFC;

   typedef enum logic [2:0] {
      S_IDLE, S_GRANT, S_TXPOLL, S_SEND, S_RXPOLL, S_POP, S_EVAL, S_DONE
   } state_t;

   state_t          r_state, w_state_nxt;
   logic            r_rst_pend, r_led_pend;
   logic [2:0]      r_led_mask, r_cur_mask;
   logic            r_is_rst, r_step;
   logic [RW-1:0]   r_retries;
   logic [TW-1:0]   r_timer;
   logic [7:0]      r_rx_byte;
   logic            r_busy, r_cpu_inflight, r_cpu_held;
   logic            r_ps2_cs, r_ps2_wr;
   logic [1:0]      r_ps2_bsel;
   logic [15:0]     r_ps2_wdata;
   logic            r_seq_done;
   logic [1:0]      r_seq_err;

   logic            w_cpu_req, w_cpu_new, w_cpu_fwd;
   logic            w_launch, w_l_wr;
   logic [1:0]      w_l_bsel;
   logic [15:0]     w_l_wdata;
   logic            w_grant, w_release, w_done, w_step_adv;
   logic            w_timer_clr, w_retry_inc, w_retry_clr;
   logic [1:0]      w_err;
   logic [7:0]      w_cur_byte;
   logic [TW-1:0]   w_limit, w_timer_inc;
   logic            w_rx_valid, w_tx_busy;

   assign w_cpu_req  = cs & data_m_access;
   assign w_cpu_new  = w_cpu_req & ~r_cpu_held & ~r_cpu_inflight;
   // CPU owns the port in IDLE, and again from the cycle the sequencer releases it
   assign w_cpu_fwd  = w_cpu_new & ((r_state == S_IDLE) | (r_state == S_DONE));
   assign w_rx_valid = ps2_rdata[8];
   assign w_tx_busy  = ps2_rdata[10];
   assign w_cur_byte = r_is_rst ? 8'hFF : (r_step ? {5'b0, r_cur_mask} : 8'hED);
   assign w_limit    = (r_is_rst && r_step) ? BAT_LIM : ACK_LIM;
   // count as it stands at the end of this cycle, i.e. cycles since the send ack
   assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + TW'(1);

   assign data_m_ack      = ps2_ack & r_cpu_inflight;
   assign data_m_data_out = r_cpu_inflight ? ps2_rdata : 16'h0000;
   assign intr            = ps2_intr & ~r_busy;
   assign ps2_cs          = r_ps2_cs;
   assign ps2_access      = r_ps2_cs;
   assign ps2_wr_en       = r_ps2_wr;
   assign ps2_bytesel     = r_ps2_bsel;
   assign ps2_wdata       = r_ps2_wdata;
   assign seq_busy        = r_busy;
   assign seq_done        = r_seq_done;
   assign seq_err         = r_seq_err;

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next state; each transaction state is entered with its strobe already launched
   always_comb begin
      w_state_nxt = r_state;
      w_launch    = 1'b0;
      w_l_wr      = 1'b0;
      w_l_bsel    = 2'b00;
      w_l_wdata   = 16'h0000;
      w_grant     = 1'b0;
      w_release   = 1'b0;
      w_done      = 1'b0;
      w_err       = 2'd0;
      w_step_adv  = 1'b0;
      w_timer_clr = 1'b0;
      w_retry_inc = 1'b0;
      w_retry_clr = 1'b0;
      case (r_state)
         S_IDLE: begin
            if ((r_rst_pend || r_led_pend) && !r_cpu_inflight && !w_cpu_new) begin
               w_grant     = 1'b1;
               w_state_nxt = S_GRANT;
            end
         end
         S_GRANT: begin
            w_state_nxt = S_TXPOLL;
            w_launch    = 1'b1;
            w_l_bsel    = BSEL_STAT;
         end
         S_TXPOLL: begin
            if (ps2_ack) begin
               w_launch = 1'b1;
               if (w_tx_busy) begin
                  w_l_bsel = BSEL_STAT;
               end else begin
                  w_state_nxt = S_SEND;
                  w_l_wr      = 1'b1;
                  w_l_bsel    = BSEL_DATA;
                  w_l_wdata   = {8'h00, w_cur_byte};
               end
            end
         end
         S_SEND: begin
            if (ps2_ack) begin
               w_state_nxt = S_RXPOLL;
               w_timer_clr = 1'b1;
               w_launch    = 1'b1;
               w_l_bsel    = BSEL_STAT;
            end
         end
         S_RXPOLL: begin
            if (ps2_ack) begin
               if (w_rx_valid) begin
                  w_state_nxt = S_POP;
                  w_launch    = 1'b1;
                  w_l_bsel    = BSEL_DATA;
               end else if (w_timer_inc >= w_limit) begin
                  w_state_nxt = S_DONE;
                  w_done      = 1'b1;
                  w_err       = 2'd1;
               end else begin
                  w_launch = 1'b1;
                  w_l_bsel = BSEL_STAT;
               end
            end
         end
         S_POP: begin
            if (ps2_ack) w_state_nxt = S_EVAL;
         end
         S_EVAL: begin
            // default: discard the byte and keep polling on the running timer
            w_state_nxt = S_RXPOLL;
            w_launch    = 1'b1;
            w_l_bsel    = BSEL_STAT;
            if (r_is_rst && r_step) begin
               if (r_rx_byte == KBD_BAT_OK) begin
                  w_state_nxt = S_DONE;
                  w_launch    = 1'b0;
                  w_done      = 1'b1;
               end else if (r_rx_byte == KBD_BAT_NG) begin
                  w_state_nxt = S_DONE;
                  w_launch    = 1'b0;
                  w_done      = 1'b1;
                  w_err       = 2'd3;
               end
            end else if (r_rx_byte == KBD_ACK) begin
               if (r_is_rst) begin
                  w_step_adv  = 1'b1;
                  w_timer_clr = 1'b1;
               end else if (!r_step) begin
                  w_step_adv  = 1'b1;
                  w_retry_clr = 1'b1;
                  w_state_nxt = S_TXPOLL;
               end else begin
                  w_state_nxt = S_DONE;
                  w_launch    = 1'b0;
                  w_done      = 1'b1;
               end
            end else if (r_rx_byte == KBD_RESEND) begin
               if (r_retries < RW'(max_retries)) begin
                  w_retry_inc = 1'b1;
                  w_state_nxt = S_TXPOLL;
               end else begin
                  w_state_nxt = S_DONE;
                  w_launch    = 1'b0;
                  w_done      = 1'b1;
                  w_err       = 2'd2;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_release   = 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Pending requests, ownership and CPU transaction tracking
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rst_pend     <= 1'b0;
         r_led_pend     <= 1'b0;
         r_led_mask     <= 3'b000;
         r_busy         <= 1'b0;
         r_cpu_inflight <= 1'b0;
         r_cpu_held     <= 1'b0;
      end else begin
         if (kbd_reset_req)             r_rst_pend <= 1'b1;
         else if (w_grant && r_rst_pend) r_rst_pend <= 1'b0;
         if (led_req) begin
            r_led_pend <= 1'b1;
            r_led_mask <= led_mask;
         end else if (w_grant && !r_rst_pend) begin
            r_led_pend <= 1'b0;
         end
         if (w_grant)        r_busy <= 1'b1;
         else if (w_release) r_busy <= 1'b0;
         if (w_cpu_fwd)    r_cpu_inflight <= 1'b1;
         else if (ps2_ack) r_cpu_inflight <= 1'b0;
         if (w_cpu_fwd)       r_cpu_held <= 1'b1;
         else if (!w_cpu_req) r_cpu_held <= 1'b0;
      end
   end

   // Sequence context: which sequence, step, retries, timeout timer, popped byte
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_is_rst   <= 1'b0;
         r_step     <= 1'b0;
         r_cur_mask <= 3'b000;
         r_retries  <= '0;
         r_timer    <= '0;
         r_rx_byte  <= 8'h00;
      end else begin
         if (w_grant) begin
            r_is_rst   <= r_rst_pend;
            r_step     <= 1'b0;
            r_cur_mask <= r_led_mask;
         end else if (w_step_adv) begin
            r_step <= 1'b1;
         end
         if (w_grant || w_retry_clr) r_retries <= '0;
         else if (w_retry_inc)       r_retries <= r_retries + RW'(1);
         if (w_timer_clr) r_timer <= '0;
         else             r_timer <= w_timer_inc;
         if ((r_state == S_POP) && ps2_ack) r_rx_byte <= ps2_rdata[7:0];
      end
   end

   // Registered controller strobes and sequence result
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ps2_cs    <= 1'b0;
         r_ps2_wr    <= 1'b0;
         r_ps2_bsel  <= 2'b00;
         r_ps2_wdata <= 16'h0000;
         r_seq_done  <= 1'b0;
         r_seq_err   <= 2'd0;
      end else begin
         r_ps2_cs    <= w_launch | w_cpu_fwd;
         r_ps2_wr    <= w_cpu_fwd ? data_m_wr_en   : w_l_wr;
         r_ps2_bsel  <= w_cpu_fwd ? data_m_bytesel : w_l_bsel;
         r_ps2_wdata <= w_cpu_fwd ? data_m_data_in : w_l_wdata;
         r_seq_done  <= w_done;
         r_seq_err   <= w_err;
      end
   end

endmodule
